// File: rtl/lcd_msg_scheduler.sv
// lcd_msg_scheduler: feeds a single-line HD44780 character driver from two
// message buffers. It waits out the LCD power-on init, then sends each
// committed message round-robin. Every message goes out as exactly COLS
// characters, padded with spaces, at a fixed strobe pitch. The message then
// stays on the display for a hold time before the next grant.
//
// Ports:
//   clk, rst_n   system clock, asynchronous active-low reset
//   wr_valid[i]  requester i character valid
//   wr_data      requester i character on [8i+7:8i]
//   wr_last[i]   final character of requester i's message
//   wr_ready[i]  requester i buffer is free to be written
//   ascii_out    character to the LCD driver
//   ascii_valid  single-cycle strobe to the LCD driver
//   init_done    init wait has expired (sticky until reset)
//   active       a message is being sent or held
//   grant        requester currently or most recently displayed
module lcd_msg_scheduler #(
  parameter int unsigned CLK_HZ        = 32768,
  parameter int unsigned COLS          = 8,
  parameter int unsigned INIT_WAIT_CYC = (CLK_HZ * 60) / 1000,
  parameter int unsigned CHAR_GAP_CYC  = 16,
  parameter int unsigned HOLD_CYC      = CLK_HZ
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  wr_valid,
  input  logic [15:0] wr_data,
  input  logic [1:0]  wr_last,
  output logic [1:0]  wr_ready,
  output logic [7:0]  ascii_out,
  output logic        ascii_valid,
  output logic        init_done,
  output logic        active,
  output logic        grant
);

  localparam int unsigned IDX_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int unsigned CNT_W = $clog2(COLS + 1);
  localparam int unsigned TMR_W = 16;

  typedef enum logic [2:0] {S_INIT, S_IDLE, S_SEND, S_GAP, S_HOLD} state_t;

  state_t           state;
  logic [TMR_W-1:0] tmr;
  logic [IDX_W-1:0] idx;
  logic             rr_last;
  logic [1:0]       committed;
  logic [CNT_W-1:0] wcnt [2];
  logic [CNT_W-1:0] len  [2];
  logic [7:0]       msg_buf [2][COLS];

  logic             pick_c;
  logic             sel_g_c;
  logic [IDX_W-1:0] sel_idx_c;
  logic [7:0]       next_char_c;

  assign wr_ready = ~committed;

  // Character storage; contents only matter once the buffer is committed.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (wr_valid[i] && !committed[i] && (wcnt[i] < CNT_W'(COLS)))
        msg_buf[i][wcnt[i][IDX_W-1:0]] <= wr_data[8*i +: 8];
    end
  end

  // Requester to grant: the only committed one, or the one not served last.
  // The next character is either the one for slot 0 of that requester
  // (leaving idle) or the one for slot idx of the current grant (leaving
  // the gap); slots past the message length are padded with spaces.
  always_comb begin
    pick_c      = (committed == 2'b11) ? ~rr_last : committed[1];
    sel_g_c     = (state == S_IDLE) ? pick_c : grant;
    sel_idx_c   = (state == S_IDLE) ? '0 : idx;
    next_char_c = (CNT_W'(sel_idx_c) < len[sel_g_c]) ?
                  msg_buf[sel_g_c][sel_idx_c] : 8'h20;
  end

  // Write bookkeeping and the scheduler FSM. ascii_valid is raised on the
  // transition into S_SEND, so the strobe is high exactly while in S_SEND.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_INIT;
      tmr         <= TMR_W'(INIT_WAIT_CYC);
      idx         <= '0;
      rr_last     <= 1'b1;
      committed   <= 2'b00;
      ascii_out   <= 8'h20;
      ascii_valid <= 1'b0;
      init_done   <= 1'b0;
      active      <= 1'b0;
      grant       <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        wcnt[i] <= '0;
        len[i]  <= '0;
      end
    end else begin
      // Write side runs in every state; overlong characters are counted
      // up to COLS and dropped.
      for (int i = 0; i < 2; i++) begin
        if (wr_valid[i] && !committed[i]) begin
          if (wr_last[i]) begin
            committed[i] <= 1'b1;
            len[i]       <= (wcnt[i] < CNT_W'(COLS)) ? wcnt[i] + CNT_W'(1)
                                                     : CNT_W'(COLS);
            wcnt[i]      <= '0;
          end else if (wcnt[i] < CNT_W'(COLS)) begin
            wcnt[i] <= wcnt[i] + CNT_W'(1);
          end
        end
      end

      ascii_valid <= 1'b0;

      case (state)
        S_INIT: begin
          if (tmr == '0) begin
            init_done <= 1'b1;
            state     <= S_IDLE;
          end else begin
            tmr <= tmr - TMR_W'(1);
          end
        end
        S_IDLE: begin
          if (|committed) begin
            grant       <= pick_c;
            active      <= 1'b1;
            idx         <= '0;
            ascii_valid <= 1'b1;
            ascii_out   <= next_char_c;
            state       <= S_SEND;
          end
        end
        S_SEND: begin
          if (idx == IDX_W'(COLS - 1)) begin
            committed[grant] <= 1'b0;
            rr_last          <= grant;
            tmr              <= TMR_W'(HOLD_CYC - 1);
            state            <= S_HOLD;
          end else begin
            idx   <= idx + IDX_W'(1);
            tmr   <= TMR_W'(CHAR_GAP_CYC - 2);
            state <= S_GAP;
          end
        end
        S_GAP: begin
          if (tmr == '0) begin
            ascii_valid <= 1'b1;
            ascii_out   <= next_char_c;
            state       <= S_SEND;
          end else begin
            tmr <= tmr - TMR_W'(1);
          end
        end
        S_HOLD: begin
          if (tmr == '0) begin
            active <= 1'b0;
            state  <= S_IDLE;
          end else begin
            tmr <= tmr - TMR_W'(1);
          end
        end
        default: state <= S_INIT;
      endcase
    end
  end

endmodule
